mem_lsu: RTL and testbench
==========================

// Module: mem_lsu
// PURPOSE
// Parametrised load/store unit for the MEM pipeline stage, between exe_mem and mem_wb.
// Drives a RAM port with a req/gnt/rvalid handshake and writes with byte enables, so stores need no read-modify-write.
// Stalls the pipeline while an access is outstanding, and extracts and extends load data.
// Raises misaligned-access and timeout access-fault exceptions.
// PARAMETERS
// DATA_WIDTH   32   RAM/register data width; legal values are 32 or 64 (64 enables LD/LWU/SD)
// ADDR_WIDTH   32   byte address width
// RADDR_WIDTH  5    register-file address width
// TIMEOUT      255  cycles to wait for ram_gnt_i or ram_rvalid_i before an access fault; must be >=1
// PORTS
// clk_i         in   1            clock
// rst_n_i       in   1            asynchronous, active-low reset
// in_valid_i    in   1            exe_mem presents an instruction
// in_ready_o    out  1            mem_lsu accepts it: the transfer occurs when in_valid_i & in_ready_o
// mem_op_i      in   4            `MEM_OP code: NONE,LB,LH,LW,LBU,LHU,SB,SH,SW,LD,LWU,SD
// mem_addr_i    in   ADDR_WIDTH   effective address
// mem_data_i    in   DATA_WIDTH   store data, right-aligned
// reg_waddr_i   in   RADDR_WIDTH  destination register
// reg_we_i      in   1            register write enable
// reg_wdata_i   in   DATA_WIDTH   ALU result; forwarded as-is for non-memory ops
// csr_we_i/csr_waddr_i/csr_wdata_i  in  1/ADDR_WIDTH/DATA_WIDTH  CSR write, passed through unchanged
// inst_addr_i   in   ADDR_WIDTH   pc of the instruction
// exception_i   in   32           incoming exception; 0 means none
// ram_req_o     out  1            access request
// ram_gnt_i     in   1            request accepted this cycle
// ram_we_o      out  1            1 = store
// ram_addr_o    out  ADDR_WIDTH   word-aligned address (low log2(DATA_WIDTH/8) bits forced to 0)
// ram_be_o      out  DATA_WIDTH/8 byte enables
// ram_wdata_o   out  DATA_WIDTH   store data shifted into its byte lanes
// ram_rvalid_i  in   1            read data valid, one cycle per accepted load
// ram_rdata_i   in   DATA_WIDTH   read data, whole word
// stall_o       out  1            = ~in_ready_o; holds the upstream stages
// wb_valid_o    out  1            the registered outputs below are valid this cycle
// reg_waddr_o/reg_we_o/reg_wdata_o, csr_we_o/csr_waddr_o/csr_wdata_o, inst_addr_o, exception_o   out   registered to mem_wb
// BEHAVIOUR
// Reset (async, rst_n_i=0): state IDLE, all outputs 0, timeout counter 0.
// FSM states: IDLE, REQ, RESP.
//  - IDLE: in_ready_o=1.
//    - Accept with a non-memory op, or with exception_i!=0: registered pass-through, wb_valid_o=1 next cycle, no RAM activity.
//    - Accept with a misaligned memory op: no RAM request. wb_valid_o=1 next cycle with reg_we_o=0.
//      exception_o is 4 for a load, 6 for a store (halfword addr[0]!=0; word addr[1:0]!=0; dword addr[2:0]!=0).
//    - Accept with an aligned memory op: latch the request, go to REQ, ram_req_o=1 from the next cycle.
//  - REQ: ram_req_o=1 with stable addr/we/be/wdata until ram_gnt_i.
//    - On gnt, a store completes: wb_valid_o=1 next cycle with reg_we_o=0, then IDLE.
//    - On gnt, a load goes to RESP.
//  - RESP: ram_req_o=0. On ram_rvalid_i: extract the lane by addr offset, sign-extend (LB/LH/LW@64) or zero-extend (LBU/LHU/LWU).
//    wb_valid_o=1 next cycle with reg_wdata_o = the extended value. Then IDLE.
//  - in_ready_o=0 in REQ and RESP; exe_mem must hold its inputs while stalled.
// Timeout: the counter runs in REQ and RESP and resets on every state entry. When it reaches TIMEOUT:
//  - abort to IDLE, wb_valid_o=1, reg_we_o=0, exception_o = 5 (load) or 7 (store).
//  - A late ram_rvalid_i arriving in IDLE is ignored.
// Byte enables: SB -> 1 bit at the offset; SH -> 2 bits; SW -> 4 bits; SD -> all bits. Loads drive all-ones.
// Latency from the accept cycle, with immediate gnt and rvalid: pass-through 1 cycle; store 2 cycles; load 3 cycles.
// Simultaneous gnt and rvalid in REQ: gnt is taken; rvalid counts only in RESP (the RAM must not do this).
// wb_valid_o is a single-cycle pulse; the other registered outputs hold their last value when wb_valid_o=0.
// Reset asserted mid-access drops the access immediately; the RAM side must tolerate req falling before gnt.
// STRUCTURE
// Shared package defines.v: `MEM_OP codes (4-bit), exception cause constants (4,5,6,7), `ZERO.
// Sub-module lsu_align (combinational): generates be/wdata from op+offset and extracts+extends rdata. It is reused by a future D-cache.
// TESTING
// 1. LW addr 0x100, gnt next cycle, rvalid +2 -> ram_addr_o=0x100, ram_be_o=4'hF; wb_valid_o once, reg_wdata_o=rdata; stall_o high in REQ/RESP.
// 2. LB addr 0x103, rdata 0x80FF_FFFF -> 0xFFFFFF80; LBU same -> 0x00000080.
// 3. SB addr 0x102, data 0xAB -> ram_be_o=4'b0100, ram_wdata_o=0x00AB0000; reg_we_o=0.
// 4. LH addr 0x101 -> no ram_req_o, exception_o=4 next cycle; SW 0x102 -> exception_o=6.
// 5. TIMEOUT=4, gnt never asserted -> abort after 4 cycles, exception_o=7; stall_o returns to 0.
// 6. rst_n_i pulsed low in RESP -> all outputs 0 asynchronously; a later rvalid produces no wb_valid_o.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
package mem_lsu_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8,
    MEM_LD   = 4'd9,
    MEM_LWU  = 4'd10,
    MEM_SD   = 4'd11
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } lsu_state_e;

  localparam logic [31:0] EXC_NONE        = 32'd0;
  localparam logic [31:0] EXC_LD_MISALIGN = 32'd4;
  localparam logic [31:0] EXC_LD_FAULT    = 32'd5;
  localparam logic [31:0] EXC_ST_MISALIGN = 32'd6;
  localparam logic [31:0] EXC_ST_FAULT    = 32'd7;

  function automatic logic is_store(mem_op_e op);
    return op inside {MEM_SB, MEM_SH, MEM_SW, MEM_SD};
  endfunction

  // Codes above SD are undefined and flow through as non-memory ops.
  function automatic logic is_mem(mem_op_e op);
    return (op != MEM_NONE) && (op <= MEM_SD);
  endfunction

  function automatic logic misaligned(mem_op_e op, logic [2:0] lo);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return lo[0];
      MEM_LW, MEM_LWU, MEM_SW: return |lo[1:0];
      MEM_LD, MEM_SD:          return |lo;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// RAM port of the load/store unit: req/gnt request, rvalid response.
interface mem_lsu_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          gnt;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW/8-1:0] be;
  logic [DW-1:0] wdata;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_lsu_align.sv
// Byte-lane steering: store enables/data and load extract/extend.
module mem_lsu_align
  import mem_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  mem_op_e                         op,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] off,
  input  logic [DATA_WIDTH-1:0]           sdata,
  input  logic [DATA_WIDTH-1:0]           rdata,
  output logic [DATA_WIDTH/8-1:0]         be,
  output logic [DATA_WIDTH-1:0]           wdata,
  output logic [DATA_WIDTH-1:0]           ldata
);

  localparam int BW = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] lane;

  assign wdata = sdata << {off, 3'b000};
  assign lane  = rdata >> {off, 3'b000};

  always_comb begin
    be = '1;
    case (op)
      MEM_SB:  be = BW'(1) << off;
      MEM_SH:  be = BW'(3) << off;
      MEM_SW:  be = BW'(15) << off;
      default: be = '1;
    endcase
  end

  always_comb begin
    ldata = lane;
    case (op)
      MEM_LB:  ldata = DATA_WIDTH'($signed(lane[7:0]));
      MEM_LH:  ldata = DATA_WIDTH'($signed(lane[15:0]));
      MEM_LW:  ldata = DATA_WIDTH'($signed(lane[31:0]));
      MEM_LBU: ldata = DATA_WIDTH'(lane[7:0]);
      MEM_LHU: ldata = DATA_WIDTH'(lane[15:0]);
      MEM_LWU: ldata = DATA_WIDTH'(lane[31:0]);
      default: ldata = lane;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: RAM handshake, stall, writeback register.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int RADDR_WIDTH = 5,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  mem_op_e                mem_op_i,
  input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
  input  logic [DATA_WIDTH-1:0]  mem_data_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   reg_we_i,
  input  logic [DATA_WIDTH-1:0]  reg_wdata_i,
  input  logic                   csr_we_i,
  input  logic [ADDR_WIDTH-1:0]  csr_waddr_i,
  input  logic [DATA_WIDTH-1:0]  csr_wdata_i,
  input  logic [ADDR_WIDTH-1:0]  inst_addr_i,
  input  logic [31:0]            exception_i,
  mem_lsu_if.master              ram,
  output logic                   stall_o,
  output logic                   wb_valid_o,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   reg_we_o,
  output logic [DATA_WIDTH-1:0]  reg_wdata_o,
  output logic                   csr_we_o,
  output logic [ADDR_WIDTH-1:0]  csr_waddr_o,
  output logic [DATA_WIDTH-1:0]  csr_wdata_o,
  output logic [ADDR_WIDTH-1:0]  inst_addr_o,
  output logic [31:0]            exception_o
);

  localparam int OW = $clog2(DATA_WIDTH / 8);
  localparam int CW = $clog2(TIMEOUT + 1);

  lsu_state_e             st;
  logic [CW-1:0]          cnt;
  mem_op_e                op_q;
  logic [OW-1:0]          off_q;
  logic [RADDR_WIDTH-1:0] waddr_q;
  logic                   we_q;
  logic [DATA_WIDTH-1:0]  alu_q;
  logic                   csr_we_q;
  logic [ADDR_WIDTH-1:0]  csr_waddr_q;
  logic [DATA_WIDTH-1:0]  csr_wdata_q;
  logic [ADDR_WIDTH-1:0]  pc_q;

  mem_op_e               op_sel;
  logic [OW-1:0]         off_sel;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] ldata;

  logic take, bypass, mis, go, expire;
  logic st_done, ld_done, abort;

  // One aligner serves both the accept cycle and the response.
  assign op_sel  = (st == ST_IDLE) ? mem_op_i : op_q;
  assign off_sel = (st == ST_IDLE) ? mem_addr_i[OW-1:0] : off_q;

  mem_lsu_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .op    (op_sel),
    .off   (off_sel),
    .sdata (mem_data_i),
    .rdata (ram.rdata),
    .be    (be),
    .wdata (wdata),
    .ldata (ldata)
  );

  assign in_ready_o = (st == ST_IDLE);
  assign stall_o    = ~in_ready_o;

  assign take   = in_valid_i & in_ready_o;
  assign bypass = take &
    (!is_mem(mem_op_i) || exception_i != '0);
  assign mis    = take & !bypass &
    misaligned(mem_op_i, mem_addr_i[2:0]);
  assign go     = take & !bypass & !mis;
  assign expire = (cnt == CW'(TIMEOUT - 1));

  assign st_done = (st == ST_REQ) & ram.gnt & is_store(op_q);
  assign ld_done = (st == ST_RESP) & ram.rvalid;
  assign abort   = expire &
    (((st == ST_REQ) & !ram.gnt) |
     ((st == ST_RESP) & !ram.rvalid));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      st          <= ST_IDLE;
      cnt         <= '0;
      ram.req     <= 1'b0;
      ram.we      <= 1'b0;
      ram.addr    <= '0;
      ram.be      <= '0;
      ram.wdata   <= '0;
      op_q        <= MEM_NONE;
      off_q       <= '0;
      waddr_q     <= '0;
      we_q        <= 1'b0;
      alu_q       <= '0;
      csr_we_q    <= 1'b0;
      csr_waddr_q <= '0;
      csr_wdata_q <= '0;
      pc_q        <= '0;
      wb_valid_o  <= 1'b0;
      reg_waddr_o <= '0;
      reg_we_o    <= 1'b0;
      reg_wdata_o <= '0;
      csr_we_o    <= 1'b0;
      csr_waddr_o <= '0;
      csr_wdata_o <= '0;
      inst_addr_o <= '0;
      exception_o <= '0;
    end else begin
      wb_valid_o <= bypass | mis | st_done | ld_done | abort;
      unique case (st)
        ST_IDLE: if (go) begin
          st          <= ST_REQ;
          cnt         <= '0;
          ram.req     <= 1'b1;
          ram.we      <= is_store(mem_op_i);
          ram.addr    <= {mem_addr_i[ADDR_WIDTH-1:OW], OW'(0)};
          ram.be      <= be;
          ram.wdata   <= wdata;
          op_q        <= mem_op_i;
          off_q       <= mem_addr_i[OW-1:0];
          waddr_q     <= reg_waddr_i;
          we_q        <= reg_we_i;
          alu_q       <= reg_wdata_i;
          csr_we_q    <= csr_we_i;
          csr_waddr_q <= csr_waddr_i;
          csr_wdata_q <= csr_wdata_i;
          pc_q        <= inst_addr_i;
        end
        ST_REQ: begin
          if (ram.gnt) begin
            ram.req <= 1'b0;
            cnt     <= '0;
            st      <= is_store(op_q) ? ST_IDLE : ST_RESP;
          end else if (expire) begin
            ram.req <= 1'b0;
            st      <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RESP: begin
          if (ram.rvalid || expire) st <= ST_IDLE;
          else cnt <= cnt + CW'(1);
        end
        default: st <= ST_IDLE;
      endcase
      if (bypass | mis) begin
        reg_waddr_o <= reg_waddr_i;
        reg_we_o    <= reg_we_i & bypass;
        reg_wdata_o <= reg_wdata_i;
        csr_we_o    <= csr_we_i;
        csr_waddr_o <= csr_waddr_i;
        csr_wdata_o <= csr_wdata_i;
        inst_addr_o <= inst_addr_i;
        exception_o <= bypass ? exception_i :
          is_store(mem_op_i) ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
      end else if (st_done | ld_done | abort) begin
        reg_waddr_o <= waddr_q;
        reg_we_o    <= ld_done & we_q;
        reg_wdata_o <= ld_done ? ldata : alu_q;
        csr_we_o    <= csr_we_q;
        csr_waddr_o <= csr_waddr_q;
        csr_wdata_o <= csr_wdata_q;
        inst_addr_o <= pc_q;
        exception_o <= !abort ? EXC_NONE :
          is_store(op_q) ? EXC_ST_FAULT : EXC_LD_FAULT;
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: loads, stores, misalign, timeout, reset.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  mem_op_e     mem_op = MEM_NONE;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_data = '0;
  logic [4:0]  reg_waddr = 5'd9;
  logic        reg_we = 1'b1;
  logic [31:0] reg_wdata = 32'h1111_2222;
  logic        csr_we = 1'b0;
  logic [31:0] csr_waddr = '0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] inst_addr = 32'h80;
  logic [31:0] exception = '0;
  logic        stall, wb_valid;
  logic [4:0]  wb_waddr;
  logic        wb_we;
  logic [31:0] wb_wdata;
  logic        wb_csr_we;
  logic [31:0] wb_csr_waddr, wb_csr_wdata;
  logic [31:0] wb_inst_addr, wb_exc;

  int n_chk = 0;
  int n_fail = 0;

  mem_lsu_if #(.AW(32), .DW(32)) ram ();

  mem_lsu #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (32),
    .RADDR_WIDTH (5),
    .TIMEOUT     (4)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .mem_op_i    (mem_op),
    .mem_addr_i  (mem_addr),
    .mem_data_i  (mem_data),
    .reg_waddr_i (reg_waddr),
    .reg_we_i    (reg_we),
    .reg_wdata_i (reg_wdata),
    .csr_we_i    (csr_we),
    .csr_waddr_i (csr_waddr),
    .csr_wdata_i (csr_wdata),
    .inst_addr_i (inst_addr),
    .exception_i (exception),
    .ram         (ram),
    .stall_o     (stall),
    .wb_valid_o  (wb_valid),
    .reg_waddr_o (wb_waddr),
    .reg_we_o    (wb_we),
    .reg_wdata_o (wb_wdata),
    .csr_we_o    (wb_csr_we),
    .csr_waddr_o (wb_csr_waddr),
    .csr_wdata_o (wb_csr_wdata),
    .inst_addr_o (wb_inst_addr),
    .exception_o (wb_exc)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(mem_op_e op, logic [31:0] a, logic [31:0] d);
    in_valid = 1'b1;
    mem_op   = op;
    mem_addr = a;
    mem_data = d;
    chk("in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    mem_op   = MEM_NONE;
  endtask

  task automatic load(string tag, mem_op_e op, logic [31:0] a,
                      logic [31:0] rd, logic [31:0] exp);
    issue(op, a, '0);
    chk({tag, "_req"}, ram.req, 1);
    ram.gnt = 1'b1;
    tick();
    ram.gnt = 1'b0;
    ram.rvalid = 1'b1;
    ram.rdata = rd;
    tick();
    ram.rvalid = 1'b0;
    chk({tag, "_wbv"}, wb_valid, 1);
    chk({tag, "_data"}, wb_wdata, exp);
  endtask

  task automatic store(string tag, mem_op_e op, logic [31:0] a,
                       logic [31:0] d, logic [31:0] ea,
                       logic [3:0] ebe, logic [31:0] ewd);
    issue(op, a, d);
    chk({tag, "_req"}, ram.req, 1);
    chk({tag, "_we"}, ram.we, 1);
    chk({tag, "_addr"}, ram.addr, ea);
    chk({tag, "_be"}, ram.be, ebe);
    chk({tag, "_wdata"}, ram.wdata, ewd);
    ram.gnt = 1'b1;
    tick();
    ram.gnt = 1'b0;
    chk({tag, "_wbv"}, wb_valid, 1);
    chk({tag, "_rwe"}, wb_we, 0);
    chk({tag, "_exc"}, wb_exc, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ram.gnt = 1'b0;
    ram.rvalid = 1'b0;
    ram.rdata = '0;
    #1;
    chk("rst_req", ram.req, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_exc", wb_exc, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // LW with one wait cycle in RESP
    issue(MEM_LW, 32'h100, '0);
    chk("lw_req", ram.req, 1);
    chk("lw_addr", ram.addr, 32'h100);
    chk("lw_be", ram.be, 4'hF);
    chk("lw_we", ram.we, 0);
    chk("lw_stall_req", stall, 1);
    ram.gnt = 1'b1;
    tick();
    ram.gnt = 1'b0;
    chk("lw_req_drop", ram.req, 0);
    chk("lw_stall_resp", stall, 1);
    chk("lw_wbv_early", wb_valid, 0);
    tick();
    ram.rvalid = 1'b1;
    ram.rdata = 32'h1234_5678;
    tick();
    ram.rvalid = 1'b0;
    chk("lw_wbv", wb_valid, 1);
    chk("lw_data", wb_wdata, 32'h1234_5678);
    chk("lw_rwe", wb_we, 1);
    chk("lw_waddr", wb_waddr, 9);
    chk("lw_stall_end", stall, 0);
    tick();
    chk("lw_pulse", wb_valid, 0);
    chk("lw_hold", wb_wdata, 32'h1234_5678);

    load("lb", MEM_LB, 32'h103, 32'h80FF_FFFF, 32'hFFFF_FF80);
    load("lbu", MEM_LBU, 32'h103, 32'h80FF_FFFF, 32'h0000_0080);
    load("lh", MEM_LH, 32'h102, 32'h80FF_FFFF, 32'hFFFF_80FF);
    load("lhu", MEM_LHU, 32'h102, 32'h80FF_FFFF, 32'h0000_80FF);
    load("lb0", MEM_LB, 32'h100, 32'h0000_007F, 32'h0000_007F);

    store("sb", MEM_SB, 32'h102, 32'hAB, 32'h100, 4'b0100,
          32'h00AB_0000);
    store("sh", MEM_SH, 32'h102, 32'h1234, 32'h100, 4'b1100,
          32'h1234_0000);
    store("sw", MEM_SW, 32'h104, 32'hDEAD_BEEF, 32'h104, 4'hF,
          32'hDEAD_BEEF);

    // non-memory pass-through
    reg_wdata = 32'hCAFE_F00D;
    reg_waddr = 5'd7;
    csr_we = 1'b1;
    csr_waddr = 32'h300;
    csr_wdata = 32'h55;
    inst_addr = 32'h84;
    issue(MEM_NONE, 32'h0, '0);
    chk("pt_req", ram.req, 0);
    chk("pt_wbv", wb_valid, 1);
    chk("pt_data", wb_wdata, 32'hCAFE_F00D);
    chk("pt_waddr", wb_waddr, 7);
    chk("pt_rwe", wb_we, 1);
    chk("pt_csrwe", wb_csr_we, 1);
    chk("pt_csra", wb_csr_waddr, 32'h300);
    chk("pt_csrd", wb_csr_wdata, 32'h55);
    chk("pt_pc", wb_inst_addr, 32'h84);
    csr_we = 1'b0;

    exception = 32'd2;
    issue(MEM_LW, 32'h100, '0);
    chk("exin_req", ram.req, 0);
    chk("exin_exc", wb_exc, 2);
    exception = '0;

    issue(MEM_LH, 32'h101, '0);
    chk("mal_req", ram.req, 0);
    chk("mal_wbv", wb_valid, 1);
    chk("mal_exc", wb_exc, 4);
    chk("mal_rwe", wb_we, 0);
    issue(MEM_SW, 32'h102, 32'h1);
    chk("msa_req", ram.req, 0);
    chk("msa_exc", wb_exc, 6);

    // store with no grant: four request cycles then fault
    issue(MEM_SW, 32'h200, 32'h9);
    for (int i = 0; i < 4; i++) begin
      chk("sto_req", ram.req, 1);
      chk("sto_stall", stall, 1);
      tick();
    end
    chk("sto_wbv", wb_valid, 1);
    chk("sto_exc", wb_exc, 7);
    chk("sto_req_end", ram.req, 0);
    chk("sto_stall_end", stall, 0);

    // load granted but never answered
    issue(MEM_LW, 32'h300, '0);
    ram.gnt = 1'b1;
    tick();
    ram.gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("lto_stall", stall, 1);
      tick();
    end
    chk("lto_wbv", wb_valid, 1);
    chk("lto_exc", wb_exc, 5);
    chk("lto_rwe", wb_we, 0);

    // reset mid-response
    tick();
    issue(MEM_LW, 32'h100, '0);
    ram.gnt = 1'b1;
    tick();
    ram.gnt = 1'b0;
    chk("rr_stall_pre", stall, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr_stall", stall, 0);
    chk("rr_data", wb_wdata, 0);
    chk("rr_exc", wb_exc, 0);
    chk("rr_waddr", wb_waddr, 0);
    chk("rr_req", ram.req, 0);
    #1;
    rst_n = 1'b1;
    ram.rvalid = 1'b1;
    ram.rdata = 32'hFFFF_FFFF;
    tick();
    ram.rvalid = 1'b0;
    chk("rr_late_wbv", wb_valid, 0);
    tick();
    chk("rr_late_wbv2", wb_valid, 0);
    chk("rr_late_data", wb_wdata, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
